hyster_stream: RTL and testbench

- Streaming, parametrised hysteresis thresholding stage for the Toonify edge path.
- Accepts one raster-order pixel per cycle from the edge-magnitude stage and forms a 3x3 window internally from line storage.
- Emits a 1-bit edge map in raster order with frame and line markers.
- Low/high thresholds and output polarity are set at runtime. Image borders are zero-padded. An end-of-frame flush drains pending outputs.

---
 rtl/hyster_stream.sv | 214 +++++++++++++++++++++
 tb/tb_hyster_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyster_stream.sv
// hyster_stream: streaming 3x3 hysteresis thresholding stage.
// Takes one raster-order magnitude pixel per accepted cycle. It keeps a
// (2*IMG_W+3)-pixel window history and emits a 1-bit edge map in raster
// order. Output k is decided when input k+IMG_W+1 is accepted. The last
// IMG_W+1 outputs of a frame are drained in FLUSH.
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_thr_low, i_thr_high    centre / neighbour thresholds (latched at sof)
//   i_pol                    output polarity (latched at sof)
//   i_valid, i_sof, i_pixel  input stream
//   o_ready                  input accepted this cycle when i_valid is high
//   o_valid, o_pixel         output stream
//   o_sof, o_eol, o_eof      output frame/line markers
//   o_busy                   frame in progress (RUN or FLUSH)
module hyster_stream #(
    parameter int unsigned DSIZE = 4,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DSIZE-1:0] i_thr_low,
    input  logic [DSIZE-1:0] i_thr_high,
    input  logic             i_pol,
    input  logic             i_valid,
    input  logic             i_sof,
    input  logic [DSIZE-1:0] i_pixel,
    output logic             o_ready,
    output logic             o_valid,
    output logic             o_pixel,
    output logic             o_sof,
    output logic             o_eol,
    output logic             o_eof,
    output logic             o_busy
);

    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int unsigned PW   = $clog2(IMG_W + 2);
    localparam int unsigned SR_N = 2 * IMG_W + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       state, state_n;
    logic [CW-1:0]    in_c, in_c_n, out_c, out_c_n;
    logic [RW-1:0]    in_r, in_r_n, out_r, out_r_n;
    logic [PW-1:0]    prime, prime_n;
    logic [DSIZE-1:0] thr_low_q, thr_low_n, thr_high_q, thr_high_n;
    logic             pol_q, pol_n;
    logic             valid_n, pixel_n, sof_n, eol_n, eof_n, ready_n, busy_n;

    // sr[j] holds the pixel j positions older than the newest stored one
    logic [DSIZE-1:0] sr [SR_N];

    logic             acc, start, shift, compute;
    logic             top, bot, lft, rgt, not_edge;
    logic [DSIZE-1:0] pix_in, ctr, nmax;
    logic [DSIZE-1:0] nb [8];

    // Window extraction, border masking and threshold decision
    always_comb begin
        acc     = i_valid && o_ready;
        start   = acc && i_sof;
        pix_in  = (state == S_FLUSH) ? '0 : i_pixel;
        shift   = start || (state == S_RUN && acc) || (state == S_FLUSH);
        compute = (state == S_FLUSH) ||
                  (state == S_RUN && acc && !i_sof && prime == PW'(IMG_W + 1));

        top = (out_r == '0);
        bot = (out_r == RW'(IMG_H - 1));
        lft = (out_c == '0);
        rgt = (out_c == CW'(IMG_W - 1));

        // Column masks come from the output column counter, so a line end never wraps
        nb[0] = (top || lft) ? '0 : sr[SR_N-1];
        nb[1] = top          ? '0 : sr[SR_N-2];
        nb[2] = (top || rgt) ? '0 : sr[SR_N-3];
        nb[3] = lft          ? '0 : sr[IMG_W+1];
        nb[4] = rgt          ? '0 : sr[IMG_W-1];
        nb[5] = (bot || lft) ? '0 : sr[1];
        nb[6] = bot          ? '0 : sr[0];
        nb[7] = (bot || rgt) ? '0 : pix_in;
        ctr   = sr[IMG_W];

        nmax = '0;
        for (int i = 0; i < 8; i++) begin
            if (nb[i] > nmax) begin
                nmax = nb[i];
            end
        end
        not_edge = (ctr < thr_low_q) && (nmax < thr_high_q);
    end

    // Next-state, counter and output-register logic
    always_comb begin
        state_n    = state;
        in_c_n     = in_c;
        in_r_n     = in_r;
        out_c_n    = out_c;
        out_r_n    = out_r;
        prime_n    = prime;
        thr_low_n  = thr_low_q;
        thr_high_n = thr_high_q;
        pol_n      = pol_q;
        valid_n    = 1'b0;
        pixel_n    = 1'b0;
        sof_n      = 1'b0;
        eol_n      = 1'b0;
        eof_n      = 1'b0;

        if (start) begin
            // New frame (from IDLE, or aborting RUN): pixel is (0,0)
            state_n    = S_RUN;
            in_c_n     = CW'(1);
            in_r_n     = '0;
            out_c_n    = '0;
            out_r_n    = '0;
            prime_n    = PW'(1);
            thr_low_n  = i_thr_low;
            thr_high_n = i_thr_high;
            pol_n      = i_pol;
        end else begin
            if (state == S_RUN && acc) begin
                if (prime != PW'(IMG_W + 1)) begin
                    prime_n = prime + PW'(1);
                end
                if (in_c == CW'(IMG_W - 1)) begin
                    in_c_n = '0;
                    if (in_r == RW'(IMG_H - 1)) begin
                        state_n = S_FLUSH;
                    end else begin
                        in_r_n = in_r + RW'(1);
                    end
                end else begin
                    in_c_n = in_c + CW'(1);
                end
            end

            if (compute) begin
                valid_n = 1'b1;
                pixel_n = not_edge ^ pol_q;
                sof_n   = top && lft;
                eol_n   = rgt;
                eof_n   = bot && rgt;
                if (rgt) begin
                    out_c_n = '0;
                    if (!bot) begin
                        out_r_n = out_r + RW'(1);
                    end
                end else begin
                    out_c_n = out_c + CW'(1);
                end
                if (state == S_FLUSH && bot && rgt) begin
                    state_n = S_IDLE;
                end
            end
        end

        ready_n = (state_n != S_FLUSH);
        busy_n  = (state_n != S_IDLE);
    end

    // State, counters, settings and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            in_c       <= '0;
            in_r       <= '0;
            out_c      <= '0;
            out_r      <= '0;
            prime      <= '0;
            thr_low_q  <= '0;
            thr_high_q <= '0;
            pol_q      <= 1'b0;
            o_valid    <= 1'b0;
            o_pixel    <= 1'b0;
            o_sof      <= 1'b0;
            o_eol      <= 1'b0;
            o_eof      <= 1'b0;
            o_busy     <= 1'b0;
            o_ready    <= 1'b1;
        end else begin
            state      <= state_n;
            in_c       <= in_c_n;
            in_r       <= in_r_n;
            out_c      <= out_c_n;
            out_r      <= out_r_n;
            prime      <= prime_n;
            thr_low_q  <= thr_low_n;
            thr_high_q <= thr_high_n;
            pol_q      <= pol_n;
            o_valid    <= valid_n;
            o_pixel    <= pixel_n;
            o_sof      <= sof_n;
            o_eol      <= eol_n;
            o_eof      <= eof_n;
            o_busy     <= busy_n;
            o_ready    <= ready_n;
        end
    end

    // Window history; contents are don't-care after reset
    always_ff @(posedge i_clk) begin
        if (shift) begin
            sr[0] <= pix_in;
            for (int i = 1; i < int'(SR_N); i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_hyster_stream.sv
// tb_hyster_stream: directed self-checking bench for hyster_stream
// (IMG_W=4, IMG_H=3, DSIZE=4). Expected edge maps are 12-bit vectors,
// bit k = output k in raster order.
module tb_hyster_stream;

    localparam int unsigned DSIZE = 4;
    localparam int unsigned W     = 4;
    localparam int unsigned H     = 3;
    localparam int          N     = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DSIZE-1:0] thr_low = 4'd2;
    logic [DSIZE-1:0] thr_high = 4'd3;
    logic             pol = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [DSIZE-1:0] in_pixel = '0;
    logic             o_ready, o_valid, o_pixel, o_sof, o_eol, o_eof, o_busy;

    int errors = 0;
    int checks = 0;
    int n_out = 0;
    int n_acc = 0;
    int first_at = -1;
    int sof_at = -1;
    int rl = 0;
    int rlv = 0;
    int saved = 0;

    logic             out_pix [32];
    logic             out_sof [32];
    logic             out_eol [32];
    logic             out_eof [32];
    logic [DSIZE-1:0] img [N];

    hyster_stream #(.DSIZE(DSIZE), .IMG_W(W), .IMG_H(H)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_thr_low  (thr_low),
        .i_thr_high (thr_high),
        .i_pol      (pol),
        .i_valid    (in_valid),
        .i_sof      (in_sof),
        .i_pixel    (in_pixel),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_pixel    (o_pixel),
        .o_sof      (o_sof),
        .o_eol      (o_eol),
        .o_eof      (o_eof),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Output capture on the falling edge
    always @(negedge clk) begin
        if (o_valid) begin
            if (n_out < 32) begin
                out_pix[n_out] = o_pixel;
                out_sof[n_out] = o_sof;
                out_eol[n_out] = o_eol;
                out_eof[n_out] = o_eof;
            end
            if (n_out == 0) first_at = n_acc;
            if (o_sof) sof_at = n_acc;
            n_out++;
        end
        if (!o_ready) begin
            rl++;
            if (o_valid) rlv++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DSIZE-1:0] p, input logic s);
        in_valid = 1'b1;
        in_sof   = s;
        in_pixel = p;
        @(posedge clk);
        n_acc++;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        n_out = 0; n_acc = 0; first_at = -1; sof_at = -1; rl = 0; rlv = 0;
    endtask

    task automatic img_zero();
        for (int i = 0; i < N; i++) img[i] = '0;
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < N; i++) begin
            send(img[i], (i == 0));
            if (gap > 0 && (i == 3 || i == 7)) idle(gap);
        end
    endtask

    task automatic check_frame(input string tag, input int base, input logic [11:0] exp);
        logic [11:0] vp, vs, ve, vf;
        for (int k = 0; k < N; k++) begin
            vp[k] = out_pix[base+k];
            vs[k] = out_sof[base+k];
            ve[k] = out_eol[base+k];
            vf[k] = out_eof[base+k];
        end
        chk({tag, "_pix"}, 32'(vp), 32'(exp));
        chk({tag, "_sof"}, 32'(vs), 32'h001);
        chk({tag, "_eol"}, 32'(ve), 32'h888);
        chk({tag, "_eof"}, 32'(vf), 32'h800);
    endtask

    initial begin
        // Reset held two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'({o_valid, o_pixel, o_sof, o_eol, o_eof, o_busy, o_ready}), 32'b0000001);
        rst_n = 1'b1;

        // Stray pixels without sof in IDLE are dropped
        clr();
        repeat (3) send(4'd7, 1'b0);
        idle(4);
        chk("stray_nout", 32'(n_out), 32'd0);
        chk("stray_busy", 32'(o_busy), 32'd0);

        // All-zero frame: latency, markers, flush length
        img_zero();
        clr();
        send_frame(0);
        idle(10);
        chk("zero_first", 32'(first_at), 32'd6);
        chk("zero_count", 32'(n_out), 32'd12);
        check_frame("zero", 0, 12'hFFF);
        chk("zero_flush_rdy", 32'(rl), 32'd5);
        chk("zero_flush_vld", 32'(rlv), 32'd5);
        chk("zero_end_state", 32'({o_ready, o_busy}), 32'b10);

        // Single strong centre pixel, both polarities
        img_zero();
        img[5] = 4'd5;
        clr();
        send_frame(0);
        idle(10);
        chk("ctr_count", 32'(n_out), 32'd12);
        check_frame("ctr", 0, 12'h888);
        pol = 1'b1;
        clr();
        send_frame(0);
        idle(10);
        check_frame("ctr_pol1", 0, 12'h777);
        pol = 1'b0;

        // Strict comparisons at both thresholds
        thr_low = 4'd5;
        thr_high = 4'd6;
        clr();
        send_frame(0);
        idle(10);
        check_frame("strict", 0, 12'hFDF);
        thr_low = 4'd2;
        thr_high = 4'd3;

        // Right border
        img_zero();
        img[3] = 4'd2;
        clr();
        send_frame(0);
        idle(10);
        check_frame("border", 0, 12'hFF7);

        // Left-column pixel must not wrap to the previous line end
        img_zero();
        img[4] = 4'd7;
        clr();
        send_frame(0);
        idle(10);
        check_frame("nowrap", 0, 12'hCCC);

        // Input gaps do not change results
        img_zero();
        img[5] = 4'd5;
        clr();
        send_frame(3);
        idle(10);
        chk("gap_count", 32'(n_out), 32'd12);
        check_frame("gap", 0, 12'h888);

        // Inputs driven during FLUSH are ignored
        clr();
        send_frame(0);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_pixel = 4'd9;
        idle(4);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        idle(8);
        chk("flushin_count", 32'(n_out), 32'd12);
        chk("flushin_rdy", 32'(rl), 32'd5);
        check_frame("flushin", 0, 12'h888);

        // Abort after 7 pixels, then a full frame
        img_zero();
        clr();
        for (int i = 0; i < 7; i++) send(4'd0, (i == 0));
        n_acc = 0;
        img[5] = 4'd5;
        send_frame(0);
        idle(10);
        chk("abort_count", 32'(n_out), 32'd14);
        chk("abort_sof_at", 32'(sof_at), 32'd6);
        chk("abort_old", 32'({out_sof[0], out_eof[0], out_eof[1]}), 32'b100);
        check_frame("abort", 2, 12'h888);

        // Settings changed mid-frame only apply from the next sof
        clr();
        for (int i = 0; i < N; i++) begin
            if (i == 6) begin
                thr_low = 4'd15;
                thr_high = 4'd15;
                pol = 1'b1;
            end
            send(img[i], (i == 0));
        end
        idle(10);
        check_frame("latch_old", 0, 12'h888);
        img_zero();
        clr();
        send_frame(0);
        idle(10);
        check_frame("latch_new", 0, 12'h000);
        thr_low = 4'd2;
        thr_high = 4'd3;
        pol = 1'b0;

        // Reset during FLUSH suppresses remaining outputs
        clr();
        send_frame(0);
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstfl_outs", 32'({o_valid, o_eof, o_busy, o_ready}), 32'b0001);
        chk("rstfl_count", 32'(n_out), 32'd8);
        rst_n = 1'b1;
        saved = n_out;
        idle(10);
        chk("rstfl_quiet", 32'(n_out), 32'(saved));

        // Recovery frame after reset
        clr();
        send_frame(0);
        idle(10);
        chk("recov_count", 32'(n_out), 32'd12);
        check_frame("recov", 0, 12'hFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
